// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage instruction SRAM fetch sequencer with redirect drop and stall watchdog
// One outstanding request; responses overtaken by a redirect are swallowed.
module if_fetch_ctrl #(
  parameter int          TIMEOUT  = 256,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pc_curr,
  input  logic        redirect,
  input  logic        fifo_full,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [63:0] inst_rdata,
  output logic        fetch_ok1,
  output logic        fetch_ok2,
  output logic [31:0] fetch_pc0,
  output logic [31:0] fetch_inst0,
  output logic [31:0] fetch_inst1,
  output logic        stall_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TIMEOUT_M1 = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inst_req_q, inst_req_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          stall_err_q, stall_err_d;
  logic          busy, completing;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      req_pc_q    <= RESET_PC;
      inst_req_q  <= 1'b0;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_pc_q    <= req_pc_d;
      inst_req_q  <= inst_req_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    inst_req_d = inst_req_q;
    pend_d     = pend_q;
    fetch_ok1  = 1'b0;
    fetch_ok2  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect && !fifo_full) begin
          state_d    = REQ;
          req_pc_d   = pc_curr;
          inst_req_d = 1'b1;
        end
      end
      REQ: begin
        // The address stays on the bus until accepted; a redirect only marks it stale.
        if (inst_addr_ok) begin
          inst_req_d = 1'b0;
          pend_d     = 1'b0;
          state_d    = (pend_q || redirect) ? DROP : WAIT;
        end else if (redirect) begin
          pend_d = 1'b1;
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          state_d   = IDLE;
          fetch_ok1 = !redirect;
          fetch_ok2 = !redirect && !req_pc_q[2];
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (inst_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    completing  = busy && (state_d == IDLE);
    stall_cnt_d = stall_cnt_q;
    if (completing) begin
      stall_cnt_d = '0;
    end else if (busy && stall_cnt_q != TIMEOUT_C) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    stall_err_d = stall_err_q | (busy && !completing && stall_cnt_q == TIMEOUT_M1);
  end

  assign inst_req    = inst_req_q;
  assign inst_addr   = req_pc_q;
  assign fetch_pc0   = req_pc_q;
  assign fetch_inst0 = inst_rdata[31:0];
  assign fetch_inst1 = inst_rdata[63:32];
  assign stall_err   = stall_err_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

  logic        clk;
  logic        resetn;
  logic [31:0] pc_curr;
  logic        redirect;
  logic        fifo_full;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [63:0] inst_rdata;
  logic        fetch_ok1;
  logic        fetch_ok2;
  logic [31:0] fetch_pc0;
  logic [31:0] fetch_inst0;
  logic [31:0] fetch_inst1;
  logic        stall_err;

  int errors = 0;
  int checks = 0;

  if_fetch_ctrl #(.TIMEOUT(8), .RESET_PC(32'hbfc00000)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pc_curr      (pc_curr),
    .redirect     (redirect),
    .fifo_full    (fifo_full),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .fetch_ok1    (fetch_ok1),
    .fetch_ok2    (fetch_ok2),
    .fetch_pc0    (fetch_pc0),
    .fetch_inst0  (fetch_inst0),
    .fetch_inst1  (fetch_inst1),
    .stall_err    (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; pc_curr = 32'h0; redirect = 1'b0; fifo_full = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 64'h0;
    step(); step(); #1;
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", inst_req); end
    checks++; if (inst_addr !== 32'hbfc00000) begin errors++; $display("FAIL reset_addr: got %h want bfc00000", inst_addr); end
    checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_err); end
    checks++; if ({fetch_ok1, fetch_ok2} !== 2'b00) begin errors++; $display("FAIL reset_ok: got %b want 00", {fetch_ok1, fetch_ok2}); end
    fifo_full = 1'b1;
    step(); resetn = 1'b1;
    step();
  endtask

  task automatic test_aligned_fetch();
    fifo_full = 1'b0; pc_curr = 32'hbfc00000;
    step(); #1;
    checks++; if (inst_req !== 1'b1) begin errors++; $display("FAIL t1_req: got %b want 1", inst_req); end
    checks++; if (inst_addr !== 32'hbfc00000) begin errors++; $display("FAIL t1_addr: got %h want bfc00000", inst_addr); end
    inst_addr_ok = 1'b1;
    step(); inst_addr_ok = 1'b0; #1;
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL t1_req_drop: got %b want 0", inst_req); end
    checks++; if (fetch_ok1 !== 1'b0) begin errors++; $display("FAIL t1_ok_early: got %b want 0", fetch_ok1); end
    step(); inst_data_ok = 1'b1; inst_rdata = 64'h11112222_33334444; pc_curr = 32'hbfc00008; #1;
    checks++; if ({fetch_ok1, fetch_ok2} !== 2'b11) begin errors++; $display("FAIL t1_ok: got %b want 11", {fetch_ok1, fetch_ok2}); end
    checks++; if (fetch_inst0 !== 32'h33334444) begin errors++; $display("FAIL t1_inst0: got %h want 33334444", fetch_inst0); end
    checks++; if (fetch_inst1 !== 32'h11112222) begin errors++; $display("FAIL t1_inst1: got %h want 11112222", fetch_inst1); end
    step(); inst_data_ok = 1'b0; #1;
    checks++; if ({fetch_ok1, fetch_ok2} !== 2'b00) begin errors++; $display("FAIL t1_ok_after: got %b want 00", {fetch_ok1, fetch_ok2}); end
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL t1_idle_gap: got %b want 0", inst_req); end
    step(); #1;
    checks++; if (inst_addr !== 32'hbfc00008 || inst_req !== 1'b1) begin errors++; $display("FAIL t1_next_req: got %h/%b want bfc00008/1", inst_addr, inst_req); end
    inst_addr_ok = 1'b1;
    step(); inst_addr_ok = 1'b0;
    step(); inst_data_ok = 1'b1; fifo_full = 1'b1; #1;
    checks++; if ({fetch_ok1, fetch_ok2} !== 2'b11) begin errors++; $display("FAIL t1_next_ok: got %b want 11", {fetch_ok1, fetch_ok2}); end
    step(); inst_data_ok = 1'b0;
  endtask

  task automatic test_unaligned_fetch();
    fifo_full = 1'b0; pc_curr = 32'hbfc00004;
    step(); inst_addr_ok = 1'b1; fifo_full = 1'b1; #1;
    checks++; if (inst_addr !== 32'hbfc00004) begin errors++; $display("FAIL t2_addr: got %h want bfc00004", inst_addr); end
    step(); inst_addr_ok = 1'b0;
    step(); inst_data_ok = 1'b1; inst_rdata = 64'haaaa0001_bbbb0002; #1;
    checks++; if ({fetch_ok1, fetch_ok2} !== 2'b10) begin errors++; $display("FAIL t2_ok: got %b want 10", {fetch_ok1, fetch_ok2}); end
    checks++; if (fetch_pc0 !== 32'hbfc00004) begin errors++; $display("FAIL t2_pc0: got %h want bfc00004", fetch_pc0); end
    step(); inst_data_ok = 1'b0;
  endtask

  task automatic test_redirect_wait();
    fifo_full = 1'b0; pc_curr = 32'hbfc00010;
    step(); inst_addr_ok = 1'b1; fifo_full = 1'b1;
    step(); inst_addr_ok = 1'b0; redirect = 1'b1; pc_curr = 32'hbfd00000; #1;
    checks++; if (fetch_ok1 !== 1'b0) begin errors++; $display("FAIL t3_ok_redirect: got %b want 0", fetch_ok1); end
    step(); redirect = 1'b0;
    step();
    step(); inst_data_ok = 1'b1; #1;
    checks++; if ({fetch_ok1, fetch_ok2} !== 2'b00) begin errors++; $display("FAIL t3_drop: got %b want 00", {fetch_ok1, fetch_ok2}); end
    step(); inst_data_ok = 1'b0; fifo_full = 1'b0; #1;
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL t3_idle: got %b want 0", inst_req); end
    step(); inst_addr_ok = 1'b1; fifo_full = 1'b1; #1;
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfd00000) begin errors++; $display("FAIL t3_newpc: got %b/%h want 1/bfd00000", inst_req, inst_addr); end
    step(); inst_addr_ok = 1'b0;
    step(); inst_data_ok = 1'b1; #1;
    checks++; if ({fetch_ok1, fetch_ok2} !== 2'b11) begin errors++; $display("FAIL t3_ok: got %b want 11", {fetch_ok1, fetch_ok2}); end
    step(); inst_data_ok = 1'b0;
  endtask

  task automatic test_redirect_req();
    fifo_full = 1'b0; pc_curr = 32'hbfc00020;
    step(); redirect = 1'b1; pc_curr = 32'hbfc00100; fifo_full = 1'b1;
    step(); redirect = 1'b0; #1;
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00020) begin errors++; $display("FAIL t4_hold: got %b/%h want 1/bfc00020", inst_req, inst_addr); end
    inst_addr_ok = 1'b1;
    step(); inst_addr_ok = 1'b0; #1;
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL t4_accept: got %b want 0", inst_req); end
    step(); inst_data_ok = 1'b1; #1;
    checks++; if ({fetch_ok1, fetch_ok2} !== 2'b00) begin errors++; $display("FAIL t4_pend_drop: got %b want 00", {fetch_ok1, fetch_ok2}); end
    step(); inst_data_ok = 1'b0;
    fifo_full = 1'b0; pc_curr = 32'hbfc00030;
    step(); inst_addr_ok = 1'b1; fifo_full = 1'b1;
    step(); inst_addr_ok = 1'b0;
    step(); inst_data_ok = 1'b1; redirect = 1'b1; #1;
    checks++; if ({fetch_ok1, fetch_ok2} !== 2'b00) begin errors++; $display("FAIL t4_coincident: got %b want 00", {fetch_ok1, fetch_ok2}); end
    step(); inst_data_ok = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL t5_full_hold%0d: got %b want 0", i, inst_req); end
    end
    fifo_full = 1'b0; pc_curr = 32'hbfc00040;
    step(); #1;
    checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00040) begin errors++; $display("FAIL t5_req: got %b/%h want 1/bfc00040", inst_req, inst_addr); end
    inst_addr_ok = 1'b1;
    step(); inst_addr_ok = 1'b0; fifo_full = 1'b1;
    step(); inst_data_ok = 1'b1; #1;
    checks++; if ({fetch_ok1, fetch_ok2} !== 2'b11) begin errors++; $display("FAIL t5_deliver: got %b want 11", {fetch_ok1, fetch_ok2}); end
    step(); inst_data_ok = 1'b0; #1;
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL t5_park: got %b want 0", inst_req); end
  endtask

  task automatic test_watchdog();
    fifo_full = 1'b0; pc_curr = 32'hbfc00050;
    step(); inst_addr_ok = 1'b1; fifo_full = 1'b1;
    step(); inst_addr_ok = 1'b0;
    for (int k = 2; k < 7; k++) step();
    step(); #1;
    checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL t6_early: got %b want 0", stall_err); end
    step(); #1;
    checks++; if (stall_err !== 1'b1) begin errors++; $display("FAIL t6_raise: got %b want 1", stall_err); end
    step(); step(); #1;
    checks++; if (stall_err !== 1'b1) begin errors++; $display("FAIL t6_sticky: got %b want 1", stall_err); end
    resetn = 1'b0; #1;
    checks++; if (inst_req !== 1'b0 || stall_err !== 1'b0) begin errors++; $display("FAIL t6_async_rst: got %b/%b want 0/0", inst_req, stall_err); end
    checks++; if (inst_addr !== 32'hbfc00000) begin errors++; $display("FAIL t6_rst_addr: got %h want bfc00000", inst_addr); end
    step(); resetn = 1'b1;
    step(); inst_data_ok = 1'b1; #1;
    checks++; if ({fetch_ok1, fetch_ok2} !== 2'b00) begin errors++; $display("FAIL t6_stray: got %b want 00", {fetch_ok1, fetch_ok2}); end
    step(); inst_data_ok = 1'b0; #1;
    checks++; if (inst_req !== 1'b0 || stall_err !== 1'b0) begin errors++; $display("FAIL t6_after: got %b/%b want 0/0", inst_req, stall_err); end
  endtask

  initial begin
    test_reset();
    test_aligned_fetch();
    test_unaligned_fetch();
    test_redirect_wait();
    test_redirect_req();
    test_fifo_full();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
